exu_issue_ctrl: RTL
===================

Name: exu_issue_ctrl

Overview:
Issue controller between decode and the execute unit (ALU / multiply / divide).
- Holds one instruction in an issue register and presents it to execute with a valid/ready handshake.
- Tracks every issued-but-not-retired instruction in an in-order tag FIFO, and stalls decode on RAW hazards against those entries. There is no forwarding: operands are read at decode.
- Attaches the destination register to each result returned from execute, for writeback.

Parameters:
- DEPTH, 4, maximum instructions in flight (issued to execute, result not yet accepted); power of two, ≥2.
- XLEN, 64, operand and result width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush_i  in  1  pipeline flush
- dec_valid_i  in  1  decode presents an instruction
- dec_ready_o  out  1  controller accepts the decode instruction
- dec_rs1_i, dec_rs2_i  in  5 each  source register indices
- dec_rs1_used_i, dec_rs2_used_i  in  1 each  source is actually read
- dec_rd_i  in  5  destination register index
- dec_rd_wr_i  in  1  instruction writes rd
- dec_opr_a_i, dec_opr_b_i  in  XLEN each  operands
- dec_func_i  in  4  execute function code
- dec_word_op_i, dec_mul_i, dec_div_i  in  1 each  instruction class bits
- valid_instr_o  out  1  issue register valid toward execute
- exu_ready_i  in  1  execute accepts
- opr_a_o, opr_b_o  out  XLEN each  registered operands
- exu_func_o  out  4  registered function code
- word_op_o, mul_instr_o, div_instr_o  out  1 each  registered class bits
- valid_res_i  in  1  execute result valid
- res_i  in  XLEN  execute result
- res_ready_o  out  1  result accepted; equals wb_ready_i
- wb_ready_i  in  1  writeback can accept
- wb_valid_o  out  1  result retiring this cycle
- wb_we_o  out  1  register-file write enable
- wb_rd_o  out  5  writeback destination
- wb_data_o  out  XLEN  writeback data; equals res_i

Behaviour:
Reset (synchronous, active-high):
- iss_valid=0, FIFO count=0, read/write pointers=0.
- Resulting outputs: valid_instr_o=0, dec_ready_o=0 during reset, wb_valid_o=0, wb_we_o=0.
- Data outputs are don't-care.

Definitions:
- iss_fire = valid_instr_o & exu_ready_i.
- dec_fire = dec_valid_i & dec_ready_o.
- res_fire = valid_res_i & wb_ready_i.

Busy set:
- The union of rd over all FIFO entries with rd_wr=1 and rd≠0, plus the issue-register rd if iss_valid & rd_wr & rd≠0.
- The FIFO head is still counted in the cycle it retires; release takes effect the next cycle.

Hazard and decode acceptance:
- hazard = (rs1_used & rs1∈busy) | (rs2_used & rs2∈busy). A source of x0 never causes a hazard.
- dec_ready_o = ~reset & ~flush_i & ~hazard & (~iss_valid | iss_fire) & (count + iss_valid − res_fire < DEPTH).

Issue register:
- On dec_fire it loads all dec_* fields and sets iss_valid.
- Else on iss_fire it clears iss_valid.
- Outputs hold stable while valid_instr_o=1 and exu_ready_i=0.
- Throughput is one instruction per cycle when independent.

Tag FIFO (each entry {rd, rd_wr}):
- Push on iss_fire; pop on res_fire.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- res_fire while count=0 is a protocol violation: ignored, covered by assertion.
- Execute returns results strictly in issue order; the FIFO head always matches the returning result.

Writeback:
- wb_valid_o = res_fire & ~flush_i.
- wb_rd_o = head.rd.
- wb_we_o = wb_valid_o & head.rd_wr & (head.rd≠0).
- Purely combinational from head and inputs; zero added latency.

Flush:
- Next cycle: iss_valid=0 and count=0 with pointers reset.
- During the flush cycle: dec_ready_o=0, wb_valid_o=0, and any issue or retire is discarded.
- Execute discards its own in-flight work on flush_i.

Reset has priority over flush, and flush over all other updates.

Decomposition:
- Package cpu_consts holds REG_IDX_W=5 and the execute function-code enum already used by execute.
- A tag FIFO typedef struct {rd, rd_wr} is added to cpu_consts.
- One sub-module, exu_tag_fifo: parameterised DEPTH; push/pop/clear; exposes count, head, and a flattened entry vector for busy-set generation.

Test Plan:
- Independent stream: 4 ALU ops with rd x1..x4, sources x10/x11, exu_ready_i=1, results back one cycle later -> one issue per cycle; wb_rd_o = 1,2,3,4 with wb_we_o=1.
- RAW on divide: DIV x5 (takes 20 cycles) followed by ADD x6 = x5+x7 -> dec_ready_o=0 until the cycle after the DIV retires; ADD issues the following cycle; wb_rd_o=5 then 6.
- Full: DEPTH=4 MUL ops to x8..x11 with wb_ready_i=0 -> after 4 issues dec_ready_o=0 and count=4. Raising wb_ready_i retires one per cycle, and a new independent op issues in the same cycle as the first retire.
- Execute backpressure: exu_ready_i=0 for 3 cycles -> valid_instr_o stays high and opr_a_o/exu_func_o stay stable; no FIFO push until the handshake.
- Flush mid-flight: 2 entries in FIFO plus an issue register valid, assert flush_i with valid_res_i=1 -> wb_valid_o=0 that cycle; next cycle valid_instr_o=0 and count=0, and a previously busy rd no longer stalls.
- x0 and reset: ADDI x0 followed by a read of x0 -> no stall and wb_we_o=0. Assert reset with 3 in flight -> next cycle count=0 and all outputs at reset values.

Source files
------------

// File: rtl/cpu_consts_pkg.sv
// Shared CPU constants for the execute-side blocks.
// Contents: register index width, the execute function-code enum,
// and the tag carried through the issue controller's in-flight FIFO.
package cpu_consts;

  localparam int REG_IDX_W = 5;

  typedef enum logic [3:0] {
    FN_ADD  = 4'd0,
    FN_SUB  = 4'd1,
    FN_SLL  = 4'd2,
    FN_SLT  = 4'd3,
    FN_SLTU = 4'd4,
    FN_XOR  = 4'd5,
    FN_SRL  = 4'd6,
    FN_SRA  = 4'd7,
    FN_OR   = 4'd8,
    FN_AND  = 4'd9,
    FN_MUL  = 4'd10,
    FN_MULH = 4'd11,
    FN_DIV  = 4'd12,
    FN_DIVU = 4'd13,
    FN_REM  = 4'd14,
    FN_REMU = 4'd15
  } exu_func_e;

  // One in-flight instruction: destination register and whether it writes it.
  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic                 rd_wr;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  // True when the tag will actually update the register file (x0 never does).
  function automatic logic tag_writes(tag_t t);
    return t.rd_wr && (t.rd != '0);
  endfunction

endpackage

// File: rtl/exu_tag_fifo.sv
// In-order FIFO of tags for instructions issued to execute but not yet retired.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   clear          drop all entries (pipeline flush); reset wins over clear
//   push, push_tag enqueue a tag
//   pop            dequeue the head (ignored while empty)
//   count          number of valid entries (0..DEPTH)
//   head           oldest entry
//   entries        all storage slots flattened, slot i at [i*TAG_W +: TAG_W]
//   entry_vld      per-slot valid mask, used with entries for the busy set
module exu_tag_fifo
  import cpu_consts::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [TAG_W-1:0]           push_tag,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic [TAG_W-1:0]           head,
  output logic [DEPTH*TAG_W-1:0]     entries,
  output logic [DEPTH-1:0]           entry_vld
);

  localparam int AW = $clog2(DEPTH);

  logic [TAG_W-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             pop_ok;
  logic [AW-1:0]    off;

  assign pop_ok = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_tag;
  end

  assign head = mem[rd_ptr];

  // A slot is live when its distance from the read pointer (mod DEPTH)
  // is below the occupancy.
  always_comb begin
    entries   = '0;
    entry_vld = '0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entries[i*TAG_W +: TAG_W] = mem[i];
      off          = AW'(i) - rd_ptr;
      entry_vld[i] = ({1'b0, off} < count);
    end
  end

endmodule

// File: rtl/exu_issue_ctrl.sv
// Issue controller between decode and execute (ALU / MUL / DIV).
// Holds one instruction in an issue register, tracks issued-but-unretired
// instructions in an in-order tag FIFO, stalls decode on RAW hazards against
// them (no forwarding), and tags returning results with rd for writeback.
// Ports:
//   clk, reset, flush_i                       clock, sync reset, pipeline flush
//   dec_*                                     decode handshake and instruction fields
//   valid_instr_o, exu_ready_i, opr_*/exu_func_o/class bits   issue toward execute
//   valid_res_i, res_i, res_ready_o           result return from execute
//   wb_ready_i, wb_valid_o, wb_we_o, wb_rd_o, wb_data_o       writeback
module exu_issue_ctrl
  import cpu_consts::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic                 dec_valid_i,
  output logic                 dec_ready_o,
  input  logic [4:0]           dec_rs1_i,
  input  logic [4:0]           dec_rs2_i,
  input  logic                 dec_rs1_used_i,
  input  logic                 dec_rs2_used_i,
  input  logic [4:0]           dec_rd_i,
  input  logic                 dec_rd_wr_i,
  input  logic [XLEN-1:0]      dec_opr_a_i,
  input  logic [XLEN-1:0]      dec_opr_b_i,
  input  logic [3:0]           dec_func_i,
  input  logic                 dec_word_op_i,
  input  logic                 dec_mul_i,
  input  logic                 dec_div_i,
  output logic                 valid_instr_o,
  input  logic                 exu_ready_i,
  output logic [XLEN-1:0]      opr_a_o,
  output logic [XLEN-1:0]      opr_b_o,
  output logic [3:0]           exu_func_o,
  output logic                 word_op_o,
  output logic                 mul_instr_o,
  output logic                 div_instr_o,
  input  logic                 valid_res_i,
  input  logic [XLEN-1:0]      res_i,
  output logic                 res_ready_o,
  input  logic                 wb_ready_i,
  output logic                 wb_valid_o,
  output logic                 wb_we_o,
  output logic [4:0]           wb_rd_o,
  output logic [XLEN-1:0]      wb_data_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;

  logic                 vld_p0;
  logic [REG_IDX_W-1:0] rd_p0;
  logic                 rd_wr_p0;
  logic [XLEN-1:0]      opr_a_p0;
  logic [XLEN-1:0]      opr_b_p0;
  logic [3:0]           func_p0;
  logic                 word_p0;
  logic                 mul_p0;
  logic                 div_p0;

  logic                       iss_fire;
  logic                       dec_fire;
  logic                       res_fire;
  logic                       pop_eff;
  logic [AW:0]                count;
  logic [TAG_W-1:0]           head_raw;
  tag_t                       head_tag;
  tag_t                       push_tag;
  tag_t                       ent;
  logic [DEPTH*TAG_W-1:0]     entries;
  logic [DEPTH-1:0]           entry_vld;
  logic [(1<<REG_IDX_W)-1:0]  busy;
  logic                       hazard;
  logic [CW-1:0]              occ;
  logic                       room;

  assign iss_fire = vld_p0 & exu_ready_i;
  assign res_fire = valid_res_i & wb_ready_i;
  assign pop_eff  = res_fire & (count != '0);

  // Busy set: every live FIFO entry plus the issue register. The head is
  // still counted while it retires, so a dependant waits one extra cycle.
  always_comb begin
    busy = '0;
    ent  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent = entries[i*TAG_W +: TAG_W];
      if (entry_vld[i] && tag_writes(ent)) busy[ent.rd] = 1'b1;
    end
    if (vld_p0 && rd_wr_p0 && (rd_p0 != '0)) busy[rd_p0] = 1'b1;
  end

  assign hazard = (dec_rs1_used_i & busy[dec_rs1_i]) |
                  (dec_rs2_used_i & busy[dec_rs2_i]);

  // Occupancy after this cycle's retire; the issue register counts as
  // in flight because it will push into the FIFO when it fires.
  assign occ  = CW'(count) + CW'(vld_p0) - CW'(pop_eff);
  assign room = (occ < CW'(DEPTH));

  assign dec_ready_o = ~reset & ~flush_i & ~hazard & (~vld_p0 | iss_fire) & room;
  assign dec_fire    = dec_valid_i & dec_ready_o;

  // Stage p0: issue register
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      vld_p0 <= 1'b0;
    end else if (dec_fire) begin
      vld_p0 <= 1'b1;
    end else if (iss_fire) begin
      vld_p0 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (dec_fire) begin
      rd_p0    <= dec_rd_i;
      rd_wr_p0 <= dec_rd_wr_i;
      opr_a_p0 <= dec_opr_a_i;
      opr_b_p0 <= dec_opr_b_i;
      func_p0  <= dec_func_i;
      word_p0  <= dec_word_op_i;
      mul_p0   <= dec_mul_i;
      div_p0   <= dec_div_i;
    end
  end

  assign valid_instr_o = vld_p0;
  assign opr_a_o       = opr_a_p0;
  assign opr_b_o       = opr_b_p0;
  assign exu_func_o    = func_p0;
  assign word_op_o     = word_p0;
  assign mul_instr_o   = mul_p0;
  assign div_instr_o   = div_p0;

  assign push_tag = '{rd: rd_p0, rd_wr: rd_wr_p0};

  // Flush clears the FIFO, which also discards a push or pop in that cycle.
  exu_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush_i),
    .push      (iss_fire),
    .push_tag  (push_tag),
    .pop       (res_fire),
    .count     (count),
    .head      (head_raw),
    .entries   (entries),
    .entry_vld (entry_vld)
  );

  assign head_tag = head_raw;

  assign res_ready_o = wb_ready_i;
  assign wb_valid_o  = res_fire & ~flush_i & ~reset;
  assign wb_we_o     = wb_valid_o & tag_writes(head_tag);
  assign wb_rd_o     = head_tag.rd;
  assign wb_data_o   = res_i;

  // Execute must never return a result with nothing in flight.
  res_no_underflow: assert property (@(posedge clk) disable iff (reset || flush_i)
    !(res_fire && (count == '0)));

endmodule
